// File: rtl/man_pkg.sv
// man_pkg: shared state encoding and frame constants for the Manchester transmit scheduler
package man_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;
    localparam int C_WORD_W    = 16;
    localparam int C_FRAME_CYC = 120;
endpackage

// File: rtl/man_rr_arb.sv
// man_rr_arb: combinational round-robin pick, first asserted request at or after ptr
module man_rr_arb #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       idx
);
    logic [7:0] req_x;
    logic [3:0] k;
    logic       found;
    assign req_x = 8'(req);
    always_comb begin
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = {1'b0, ptr} + 4'(i);
            if (k >= 4'(N_REQ)) k = k - 4'(N_REQ);
            if (!found && req_x[k[2:0]]) begin
                found = 1'b1;
                idx   = k[2:0];
            end
        end
    end
    assign grant = found ? N_REQ'(1) << idx : '0;
endmodule

// File: rtl/man_tx_scheduler.sv
// man_tx_scheduler: round-robin launcher sharing one Manchester encoder between requesters,
// with an enforced inter-frame gap and a timeout for a missing encoder done.
module man_tx_scheduler
    import man_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      I_sys_clk,
    input  logic                      I_rst_n,
    input  logic [N_REQ-1:0]          I_req,
    input  logic [N_REQ*C_WORD_W-1:0] I_req_data,
    output logic [N_REQ-1:0]          O_grant,
    output logic                      O_enc_start,
    output logic [C_WORD_W-1:0]       O_enc_data,
    input  logic                      I_enc_done,
    output logic                      O_busy,
    output logic [2:0]                O_cur_ch,
    output logic                      O_timeout,
    output logic [7:0]                O_err_cnt,
    output logic [15:0]               O_frame_cnt
);
    state_t              state, state_nx;
    logic [2:0]          ptr, arb_idx;
    logic [N_REQ-1:0]    arb_grant, win_oh;
    logic [7:0]          gap_cnt, to_cnt;
    logic [C_WORD_W-1:0] word_sel;
    logic                to_hit;

    man_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .req  (I_req),
        .ptr  (ptr),
        .grant(arb_grant),
        .idx  (arb_idx)
    );

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < N_REQ; i++)
            if (arb_idx == 3'(i)) word_sel = I_req_data[i*C_WORD_W +: C_WORD_W];
    end

    assign to_hit      = to_cnt == 8'(TIMEOUT_CYC - 1);
    assign O_enc_start = state == LAUNCH;
    assign O_grant     = (state == LAUNCH) ? win_oh : '0;
    assign O_busy      = state != IDLE;

    always_ff @(posedge I_sys_clk or negedge I_rst_n)
        if (!I_rst_n) state <= IDLE;
        else          state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = |I_req ? LAUNCH : IDLE;
            LAUNCH:    state_nx = WAIT_DONE;
            WAIT_DONE: state_nx = (I_enc_done || to_hit) ? GAP : WAIT_DONE;
            GAP:       state_nx = (gap_cnt == 8'(GAP_CYC - 1)) ? IDLE : GAP;
            default:   state_nx = IDLE;
        endcase
    end

    // The winner is captured once in IDLE; later req changes cannot alter the launch.
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            ptr         <= '0;
            win_oh      <= '0;
            O_cur_ch    <= '0;
            O_enc_data  <= '0;
            gap_cnt     <= '0;
            to_cnt      <= '0;
            O_timeout   <= 1'b0;
            O_err_cnt   <= '0;
            O_frame_cnt <= '0;
        end else begin
            gap_cnt   <= (state == GAP) ? gap_cnt + 8'd1 : '0;
            to_cnt    <= (state == WAIT_DONE) ? to_cnt + 8'd1 : '0;
            O_timeout <= (state == WAIT_DONE) && to_hit && !I_enc_done;
            if (state == IDLE && |I_req) begin
                win_oh     <= arb_grant;
                O_cur_ch   <= arb_idx;
                O_enc_data <= word_sel;
            end
            if (state == LAUNCH) ptr <= (O_cur_ch == 3'(N_REQ - 1)) ? '0 : O_cur_ch + 3'd1;
            if (state == WAIT_DONE && I_enc_done) O_frame_cnt <= O_frame_cnt + 16'd1;
            if (state == WAIT_DONE && to_hit && !I_enc_done && O_err_cnt != 8'hFF)
                O_err_cnt <= O_err_cnt + 8'd1;
        end
    end
endmodule
